// File: rtl/puf_response_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : puf_response_ctrl_if                                          |
// | Purpose  : Request / response bundle between a consumer and the PUF      |
// |            response controller.                                          |
// | Signals  : start, seed        request one word, starting challenge       |
// |            busy               controller is working on a word            |
// |            resp, resp_valid,  packed response word, valid/ready          |
// |            resp_ready                                                    |
// |            timeout_err        some evaluation of this word timed out     |
// | Modports : master = consumer side, slave = controller side               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface puf_response_ctrl_if #(
  parameter int CW = 32,
  parameter int RW = 16
);
  logic          start;
  logic [CW-1:0] seed;
  logic          busy;
  logic [RW-1:0] resp;
  logic          resp_valid;
  logic          resp_ready;
  logic          timeout_err;

  modport master (
    output start, seed, resp_ready,
    input  busy, resp, resp_valid, timeout_err
  );

  modport slave (
    input  start, seed, resp_ready,
    output busy, resp, resp_valid, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/puf_response_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : puf_response_ctrl                                             |
// | Purpose  : Sequences challenge/response evaluations of a race arbiter    |
// |            PUF: per bit it holds the arbiter in reset, fires one launch  |
// |            edge, waits for the (synchronized) done flag or a timeout,    |
// |            then stores the winner bit. RW bits are packed into a word    |
// |            delivered on a valid/ready handshake.                         |
// | Ports    : clk, rst         clock, synchronous active-high reset         |
// |            bus (slave)      start/seed request, resp word handshake,     |
// |                             busy and sticky timeout_err                  |
// |            chal             challenge to the delay lines                 |
// |            launch           one-cycle edge into both delay paths         |
// |            arb_rst          arbiter reset                                |
// |            arb_result/done  asynchronous arbiter outputs                 |
// | Option   : PUF_MAJORITY_VOTE_EN - evaluate each bit VOTES times with the  |
// |            same challenge and keep the majority value                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module puf_response_ctrl #(
  parameter int            CW          = 32,
  parameter int            RW          = 16,
  parameter int            ARB_RST_CYC = 2,
  parameter int            TIMEOUT     = 15,
  parameter logic [CW-1:0] LFSR_TAPS   = CW'(32'h80200003),
  parameter int            VOTES       = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  puf_response_ctrl_if.slave     bus,
  output logic [CW-1:0]          chal,
  output logic                   launch,
  output logic                   arb_rst,
  input  logic                   arb_result,
  input  logic                   arb_done
);

  localparam int CNT_MAX = (ARB_RST_CYC > TIMEOUT) ? ARB_RST_CYC : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int KW      = (RW > 1) ? $clog2(RW) : 1;

  generate
    if (ARB_RST_CYC < 1 || TIMEOUT < 3 || VOTES < 3 || (VOTES % 2) == 0) begin : g_param_err
      $error("puf_response_ctrl: illegal ARB_RST_CYC, TIMEOUT or VOTES");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_OUT     = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [KW-1:0]    k;
  logic             bit_val;
  logic [1:0]       res_sync;
  logic [1:0]       done_sync;
  logic             vote;
  logic [CW-1:0]    chal_next;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int VW = $clog2(VOTES + 1);
  logic [VW-1:0] ones;
  logic [VW-1:0] vote_idx;
`endif

  // A timed-out evaluation contributes a 0.
  assign vote      = done_sync[1] & res_sync[1];
  assign chal_next = {chal[CW-2:0], 1'b0} ^ (chal[CW-1] ? LFSR_TAPS : '0);

  // Two-flop synchronizers for the asynchronous arbiter outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_sync  <= 2'b00;
      done_sync <= 2'b00;
    end else begin
      res_sync  <= {res_sync[0], arb_result};
      done_sync <= {done_sync[0], arb_done};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      k               <= '0;
      bit_val         <= 1'b0;
      chal            <= '0;
      launch          <= 1'b0;
      arb_rst         <= 1'b1;
      bus.busy        <= 1'b0;
      bus.resp        <= '0;
      bus.resp_valid  <= 1'b0;
      bus.timeout_err <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      ones            <= '0;
      vote_idx        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            // An all-zero challenge would lock the LFSR at zero.
            chal            <= (bus.seed == '0) ? CW'(1) : bus.seed;
            k               <= '0;
            cnt             <= '0;
            bus.timeout_err <= 1'b0;
            bus.busy        <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
            ones            <= '0;
            vote_idx        <= '0;
`endif
            state           <= S_ARM;
          end
        end

        S_ARM: begin
          if (cnt == CNT_W'(ARB_RST_CYC - 1)) begin
            arb_rst <= 1'b0;
            launch  <= 1'b1;
            state   <= S_LAUNCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_LAUNCH: begin
          launch <= 1'b0;
          cnt    <= '0;
          state  <= S_WAIT;
        end

        S_WAIT: begin
          if (done_sync[1] || cnt == CNT_W'(TIMEOUT - 1)) begin
            if (!done_sync[1]) begin
              bus.timeout_err <= 1'b1;
            end
`ifdef PUF_MAJORITY_VOTE_EN
            if (vote_idx == VW'(VOTES - 1)) begin
              bit_val <= ((ones + VW'(vote)) > VW'(VOTES / 2));
              state   <= S_CAPTURE;
            end else begin
              // Re-evaluate with the same challenge.
              ones     <= ones + VW'(vote);
              vote_idx <= vote_idx + VW'(1);
              arb_rst  <= 1'b1;
              cnt      <= '0;
              state    <= S_ARM;
            end
`else
            bit_val <= vote;
            state   <= S_CAPTURE;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_CAPTURE: begin
          bus.resp[k] <= bit_val;
          chal        <= chal_next;
          arb_rst     <= 1'b1;
          cnt         <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
          ones        <= '0;
          vote_idx    <= '0;
`endif
          if (k == KW'(RW - 1)) begin
            bus.resp_valid <= 1'b1;
            state          <= S_OUT;
          end else begin
            k     <= k + KW'(1);
            state <= S_ARM;
          end
        end

        S_OUT: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.busy       <= 1'b0;
            state          <= S_IDLE;
          end
        end

        default: begin
          state   <= S_IDLE;
          launch  <= 1'b0;
          arb_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_puf_response_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_puf_response_ctrl                                          |
// | Purpose  : Self-checking bench for puf_response_ctrl. A behavioural      |
// |            arbiter answers each launch from a per-evaluation table       |
// |            (winner value, done delay or never); the expected word,       |
// |            sticky error, challenge sequence and timing are derived       |
// |            from that table.                                              |
// | Option   : PUF_MAJORITY_VOTE_EN selects the majority-vote build          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_puf_response_ctrl;

  localparam int          CW    = 32;
  localparam int          RW    = 16;
  localparam int          ARB   = 2;
  localparam int          TMO   = 15;
  localparam int          VOTES = 5;
  localparam logic [31:0] TAPS  = 32'h80200003;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int NV = VOTES;
`else
  localparam int NV = 1;
`endif
  localparam int NE = RW * NV;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] chal;
  logic          launch;
  logic          arb_rst;
  logic          arb_result = 1'b0;
  logic          arb_done   = 1'b0;

  always #5 clk = ~clk;

  puf_response_ctrl_if #(.CW(CW), .RW(RW)) bus ();

  puf_response_ctrl #(
    .CW(CW), .RW(RW), .ARB_RST_CYC(ARB), .TIMEOUT(TMO),
    .LFSR_TAPS(TAPS), .VOTES(VOTES)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .chal(chal), .launch(launch),
    .arb_rst(arb_rst), .arb_result(arb_result), .arb_done(arb_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-evaluation arbiter behaviour for the current word; dly 0 = never done.
  bit tab_val [NE];
  int tab_dly [NE];
  int ev_base = 0;

  // Observation records, appended by the monitor only.
  int            cyc = 0, ev = 0, rst_run = 0, bad_launch = 0, acnt = 0, cur_dly = 0;
  bit            prev_launch = 1'b0, armed = 1'b0, cur_val = 1'b0;
  int            launch_cyc[$];
  int            run_q[$];
  logic [CW-1:0] chal_q[$];

  // Monitor plus arbiter model, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (launch) begin
      launch_cyc.push_back(cyc);
      run_q.push_back(rst_run);
      chal_q.push_back(chal);
      if (arb_rst || prev_launch) bad_launch++;
    end
    prev_launch = launch;
    rst_run     = arb_rst ? rst_run + 1 : 0;
    if (arb_rst) begin
      armed      = 1'b0;
      arb_done   = 1'b0;
      arb_result = 1'b0;
    end else if (launch) begin
      armed = 1'b1;
      acnt  = 1;
      if (ev >= ev_base && ev - ev_base < NE) begin
        cur_dly = tab_dly[ev - ev_base];
        cur_val = tab_val[ev - ev_base];
      end else begin
        cur_dly = 1;
        cur_val = 1'b0;
      end
      ev++;
    end else if (armed) begin
      acnt++;
    end
    if (armed && cur_dly != 0 && acnt == cur_dly) begin
      arb_result = cur_val;
      arb_done   = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] c);
    return (c << 1) ^ (c[31] ? TAPS : 32'h0);
  endfunction

  // Bit b is the majority of its NV evaluations; a timed-out evaluation is 0.
  function automatic logic [RW-1:0] exp_resp();
    logic [RW-1:0] r;
    r = '0;
    for (int b = 0; b < RW; b++) begin
      int ones;
      ones = 0;
      for (int v = 0; v < NV; v++)
        if (tab_dly[b*NV+v] != 0 && tab_val[b*NV+v]) ones++;
      r[b] = (ones > NV / 2);
    end
    return r;
  endfunction

  task automatic fill(input int mode);
    for (int e = 0; e < NE; e++) begin
      int b;
      b = e / NV;
      case (mode)
        0:       begin tab_val[e] = 1'b1;         tab_dly[e] = 3; end
        1:       begin tab_val[e] = (b % 2 == 0); tab_dly[e] = 3; end
        2:       begin tab_val[e] = 1'b1;         tab_dly[e] = (b == 5) ? 0 : 3; end
        default: begin
          tab_val[e] = 1'($urandom % 2);
          tab_dly[e] = ($urandom % 16 == 0) ? 0 : int'($urandom_range(6, 1));
        end
      endcase
    end
  endtask

  task automatic do_word(input logic [CW-1:0] seed, input int hold);
    int            lb, bl0, lsz, t, bad, rbad, gap;
    bit            exp_to;
    logic [CW-1:0] c;
    logic [RW-1:0] held;
    lb      = launch_cyc.size();
    bl0     = bad_launch;
    ev_base = ev;
    bus.seed  = seed;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'(1));
    t = 0;
    while (!bus.resp_valid && t < 4000) begin
      tick();
      t++;
    end
    check("resp_valid", 64'(bus.resp_valid), 64'(1));
    check("resp", 64'(bus.resp), 64'(exp_resp()));
    exp_to = 1'b0;
    for (int e = 0; e < NE; e++) if (tab_dly[e] == 0) exp_to = 1'b1;
    check("timeout_err", 64'(bus.timeout_err), 64'(exp_to));
    check("busy_in_out", 64'(bus.busy), 64'(1));
    check("launch_count", 64'(launch_cyc.size() - lb), 64'(NE));
    check("launch_shape", 64'(bad_launch - bl0), 64'(0));
    bad  = 0;
    rbad = 0;
    c    = (seed == '0) ? 32'h1 : seed;
    for (int e = 0; e < NE; e++) begin
      if (lb + e < launch_cyc.size()) begin
        if (chal_q[lb+e] !== c) bad++;
        if (e > 0 && run_q[lb+e] != ARB) rbad++;
        if (tab_dly[e] == 0 && lb + e + 1 < launch_cyc.size()) begin
          gap = launch_cyc[lb+e+1] - launch_cyc[lb+e];
          check("timeout_wait_len", 64'(gap),
                64'(1 + TMO + ((e % NV == NV - 1) ? 1 : 0) + ARB));
        end
      end
      if (e % NV == NV - 1) c = lfsr_step(c);
    end
    check("chal_seq", 64'(bad), 64'(0));
    check("arb_rst_run", 64'(rbad), 64'(0));
    check("chal_final", 64'(chal), 64'(c));
    held = bus.resp;
    lsz  = launch_cyc.size();
    bad  = 0;
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        bus.seed  = $urandom;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (!bus.resp_valid || bus.resp !== held) bad++;
    end
    bus.start = 1'b0;
    if (hold > 0) begin
      check("hold_stable", 64'(bad), 64'(0));
      check("start_ignored", 64'(launch_cyc.size() - lsz), 64'(0));
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("valid_drop", 64'(bus.resp_valid), 64'(0));
    check("busy_idle", 64'(bus.busy), 64'(0));
    check("arb_rst_idle", 64'(arb_rst), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    64'(bus.busy),        64'(0));
    check({tag, "_chal"},    64'(chal),            64'(0));
    check({tag, "_launch"},  64'(launch),          64'(0));
    check({tag, "_arb_rst"}, 64'(arb_rst),         64'(1));
    check({tag, "_resp"},    64'(bus.resp),        64'(0));
    check({tag, "_valid"},   64'(bus.resp_valid),  64'(0));
    check({tag, "_terr"},    64'(bus.timeout_err), 64'(0));
  endtask

  task automatic reset_mid();
    int lb, t;
    fill(0);
    for (int v = 0; v < NV; v++) tab_dly[7*NV+v] = 0;
    lb      = launch_cyc.size();
    ev_base = ev;
    bus.seed  = $urandom;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t = 0;
    while (launch_cyc.size() - lb < 7 * NV + 1 && t < 4000) begin
      tick();
      t++;
    end
    check("reach_bit7", 64'(launch_cyc.size() - lb), 64'(7 * NV + 1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_rst");
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.seed       = '0;
    bus.resp_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    fill(0); do_word(32'h1, 0);        // sticky one
    fill(1); do_word($urandom, 0);     // alternating
    fill(2); do_word($urandom, 0);     // bit 5 times out
    fill(3); do_word(32'h0, 10);       // zero seed, backpressure
`ifdef PUF_MAJORITY_VOTE_EN
    fill(3);
    tab_val[0] = 1'b1; tab_val[1] = 1'b0; tab_val[2] = 1'b1; tab_val[3] = 1'b1; tab_val[4] = 1'b0;
    tab_val[5] = 1'b0; tab_val[6] = 1'b0; tab_val[7] = 1'b1; tab_val[8] = 1'b0; tab_val[9] = 1'b1;
    for (int e = 0; e < 10; e++) tab_dly[e] = 3;
    do_word($urandom, 0);
`endif
    reset_mid();
    fill(3); do_word($urandom, 0);     // fresh word after reset
    for (int i = 0; i < 6; i++) begin
      fill(3);
      do_word($urandom, (i % 2 == 1) ? int'($urandom_range(6, 1)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
